// File: rtl/aes_pkg.sv
// Shared AES datapath types: block size and the packed 16-byte block type.
package aes_pkg;
  localparam int unsigned BLOCK_BYTES = 16;
  typedef logic [BLOCK_BYTES-1:0][7:0] block_t;
endpackage

// File: rtl/block_hold_reg.sv
// One-entry block register with full flag; load wins over unload in the same cycle.
module block_hold_reg
  import aes_pkg::*;
#(
  parameter int unsigned NUM_BYTES = BLOCK_BYTES
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      load_i,
  input  logic                      unload_i,
  input  logic [NUM_BYTES-1:0][7:0] data_i,
  output logic [NUM_BYTES-1:0][7:0] data_o,
  output logic                      full_o
);

  logic [NUM_BYTES-1:0][7:0] data_d, data_q;
  logic                      full_d, full_q;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (unload_i) full_d = 1'b0;
    if (load_i) begin
      data_d = data_i;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/split_block.sv
// Serializes a multi-byte block into a byte stream, byte [0] first, with one pending block
// slot so consecutive blocks stream without a bubble; optional idle gap between bytes.
module split_block
  import aes_pkg::*;
#(
  parameter int unsigned NUM_BYTES  = BLOCK_BYTES,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [NUM_BYTES-1:0][7:0] block_in,
  input  logic                      block_valid_in,
  output logic                      block_ready_out,
  output logic [7:0]                byte_out,
  output logic                      byte_valid_out,
  input  logic                      byte_ready_in,
  output logic                      busy_out,
  output logic                      done_out
);

  localparam int unsigned IdxW = $clog2(NUM_BYTES);
  localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BYTES - 1);
  // Loaded on the xfer edge; the gap state then counts down to zero inclusive.
  localparam logic [GapW-1:0] GapInit = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e                    state_d, state_q;
  logic [IdxW-1:0]           idx_d, idx_q;
  logic [GapW-1:0]           gap_d, gap_q;
  logic [NUM_BYTES-1:0][7:0] active_d, active_q;
  logic                      done_d, done_q;

  logic                      pend_load, pend_unload, pend_full;
  logic [NUM_BYTES-1:0][7:0] pend_data;
  logic                      accept, xfer;

  assign accept = block_valid_in & ~pend_full;
  assign xfer   = (state_q == StSend) & byte_ready_in;

  block_hold_reg #(
    .NUM_BYTES(NUM_BYTES)
  ) u_pending (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .load_i  (pend_load),
    .unload_i(pend_unload),
    .data_i  (block_in),
    .data_o  (pend_data),
    .full_o  (pend_full)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    active_d    = active_q;
    done_d      = 1'b0;
    pend_load   = 1'b0;
    pend_unload = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          active_d = block_in;
          idx_d    = '0;
          state_d  = StSend;
        end
      end
      StSend: begin
        pend_load = accept;
        if (xfer) begin
          if (idx_q != LastIdx) begin
            idx_d = idx_q + IdxW'(1);
            if (GAP_CYCLES > 0) begin
              state_d = StGap;
              gap_d   = GapInit;
            end
          end else begin
            done_d = 1'b1;
            idx_d  = '0;
            // Pending block has priority; otherwise a same-cycle accept bypasses pending.
            if (pend_full) begin
              active_d    = pend_data;
              pend_unload = 1'b1;
            end else if (accept) begin
              active_d  = block_in;
              pend_load = 1'b0;
            end else begin
              state_d = StIdle;
            end
            if ((pend_full || accept) && (GAP_CYCLES > 0)) begin
              state_d = StGap;
              gap_d   = GapInit;
            end
          end
        end
      end
      StGap: begin
        pend_load = accept;
        if (gap_q == '0) begin
          state_d = StSend;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      gap_q    <= '0;
      active_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    byte_valid_out  = (state_q == StSend);
    byte_out        = byte_valid_out ? active_q[idx_q] : 8'h00;
    busy_out        = (state_q != StIdle) | pend_full;
    done_out        = done_q;
    block_ready_out = ~pend_full;
  end

endmodule

// File: tb/tb_split_block.sv
// Directed bench for split_block: one instance with no gap, one with a 3-cycle gap.
module tb_split_block;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [15:0][7:0] blk_in = '0;
  logic         valid = 1'b0;
  logic         ready = 1'b1;

  logic         rdy0, bv0, busy0, done0;
  logic [7:0]   byte0;
  logic         rdy1, bv1, busy1, done1;
  logic [7:0]   byte1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  split_block #(.NUM_BYTES(16), .GAP_CYCLES(0)) u_dut0 (
    .clk_in         (clk),
    .rst_in         (rst),
    .block_in       (blk_in),
    .block_valid_in (valid),
    .block_ready_out(rdy0),
    .byte_out       (byte0),
    .byte_valid_out (bv0),
    .byte_ready_in  (ready),
    .busy_out       (busy0),
    .done_out       (done0)
  );

  split_block #(.NUM_BYTES(16), .GAP_CYCLES(3)) u_dut1 (
    .clk_in         (clk),
    .rst_in         (rst),
    .block_in       (blk_in),
    .block_valid_in (valid),
    .block_ready_out(rdy1),
    .byte_out       (byte1),
    .byte_valid_out (bv1),
    .byte_ready_in  (ready),
    .busy_out       (busy1),
    .done_out       (done1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid = 1'b0;
    ready = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #5 rst = 1'b0;
    step();
  endtask

  task automatic load_block(input logic [7:0] base);
    for (int k = 0; k < 16; k++) blk_in[k] = 8'(base + 8'(k));
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bv0 !== 1'b0 || byte0 !== 8'h00 || done0 !== 1'b0 || busy0 !== 1'b0 || rdy0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_dut0: valid=%b byte=%h done=%b busy=%b ready=%b, want 0 00 0 0 1",
               bv0, byte0, done0, busy0, rdy0);
    end
    checks++;
    if (bv1 !== 1'b0 || byte1 !== 8'h00 || done1 !== 1'b0 || busy1 !== 1'b0 || rdy1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_dut1: valid=%b byte=%h done=%b busy=%b ready=%b, want 0 00 0 0 1",
               bv1, byte1, done1, busy1, rdy1);
    end
    #4 rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    do_reset();
    load_block(8'h00);
    valid = 1'b1;
    step();
    valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (bv0 !== 1'b1 || byte0 !== 8'(k) || done0 !== 1'b0) begin
        errors++;
        $display("FAIL single_byte%0d: valid=%b byte=%h done=%b, want 1 %h 0",
                 k, bv0, byte0, done0, 8'(k));
      end
      step();
    end
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || bv0 !== 1'b0) begin
      errors++;
      $display("FAIL single_done: done=%b busy=%b valid=%b, want 1 0 0", done0, busy0, bv0);
    end
    step();
    checks++;
    if (done0 !== 1'b0) begin
      errors++;
      $display("FAIL single_done_pulse: done=%b, want 0", done0);
    end
  endtask

  task automatic test_ready_toggle();
    int nxt;
    logic held;
    logic [7:0] prev;
    do_reset();
    load_block(8'h00);
    valid = 1'b1;
    step();
    valid = 1'b0;
    nxt = 0;
    held = 1'b0;
    prev = 8'h00;
    for (int c = 0; c < 64 && nxt < 16; c++) begin
      ready = c[0];
      if (held) begin
        checks++;
        if (bv0 !== 1'b1 || byte0 !== prev) begin
          errors++;
          $display("FAIL toggle_hold: valid=%b byte=%h, want 1 %h", bv0, byte0, prev);
        end
      end
      if (bv0 === 1'b1) begin
        if (ready) begin
          checks++;
          if (byte0 !== 8'(nxt)) begin
            errors++;
            $display("FAIL toggle_xfer%0d: byte=%h, want %h", nxt, byte0, 8'(nxt));
          end
          nxt++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          prev = byte0;
        end
      end
      step();
    end
    ready = 1'b1;
    checks++;
    if (nxt !== 16 || bv0 !== 1'b0 || done0 !== 1'b1) begin
      errors++;
      $display("FAIL toggle_count: xfers=%0d valid=%b done=%b, want 16 0 1", nxt, bv0, done0);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    load_block(8'h10);
    valid = 1'b1;
    step();
    valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k == 2) begin
        load_block(8'h20);
        valid = 1'b1;
      end else begin
        valid = 1'b0;
      end
      checks++;
      if (bv0 !== 1'b1 || byte0 !== 8'(16 + k) || done0 !== (k == 16)) begin
        errors++;
        $display("FAIL b2b_byte%0d: valid=%b byte=%h done=%b, want 1 %h %b",
                 k, bv0, byte0, done0, 8'(16 + k), (k == 16));
      end
      step();
    end
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || bv0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: done=%b busy=%b valid=%b, want 1 0 0", done0, busy0, bv0);
    end
  endtask

  task automatic test_pending_full();
    do_reset();
    load_block(8'h10);
    valid = 1'b1;
    step();
    for (int k = 0; k < 48; k++) begin
      if (k == 0) load_block(8'h20);
      if (k == 1) load_block(8'h30);
      if (k == 17) valid = 1'b0;
      if (k == 0 || k == 16) begin
        checks++;
        if (rdy0 !== 1'b1) begin
          errors++;
          $display("FAIL pend_ready_open%0d: ready=%b, want 1", k, rdy0);
        end
      end else if (k >= 1 && k <= 15) begin
        checks++;
        if (rdy0 !== 1'b0) begin
          errors++;
          $display("FAIL pend_stall%0d: ready=%b, want 0", k, rdy0);
        end
      end
      checks++;
      if (bv0 !== 1'b1 || byte0 !== 8'(16 + k)) begin
        errors++;
        $display("FAIL pend_byte%0d: valid=%b byte=%h, want 1 %h", k, bv0, byte0, 8'(16 + k));
      end
      step();
    end
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL pend_end: done=%b busy=%b, want 1 0", done0, busy0);
    end
  endtask

  task automatic test_gap();
    logic exp_v;
    do_reset();
    load_block(8'h10);
    valid = 1'b1;
    step();
    valid = 1'b0;
    for (int c = 0; c <= 124; c++) begin
      if (c == 1) begin
        load_block(8'h20);
        valid = 1'b1;
      end else begin
        valid = 1'b0;
      end
      exp_v = (c % 4 == 0);
      checks++;
      if (bv1 !== exp_v || (exp_v && byte1 !== 8'(16 + c / 4))) begin
        errors++;
        $display("FAIL gap_c%0d: valid=%b byte=%h, want %b %h", c, bv1, byte1, exp_v,
                 8'(16 + c / 4));
      end
      if (c == 61) begin
        checks++;
        if (done1 !== 1'b1) begin
          errors++;
          $display("FAIL gap_done_a: done=%b, want 1", done1);
        end
      end
      step();
    end
    checks++;
    if (done1 !== 1'b1 || bv1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL gap_end: done=%b valid=%b busy=%b, want 1 0 0", done1, bv1, busy1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_block(8'h10);
    valid = 1'b1;
    step();
    load_block(8'h20);
    step();
    valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (byte0 !== 8'h15 || busy0 !== 1'b1 || rdy0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre: byte=%h busy=%b ready=%b, want 15 1 0", byte0, busy0, rdy0);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bv0 !== 1'b0 || byte0 !== 8'h00 || done0 !== 1'b0 || busy0 !== 1'b0 || rdy0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: valid=%b byte=%h done=%b busy=%b ready=%b, want 0 00 0 0 1",
               bv0, byte0, done0, busy0, rdy0);
    end
    #2 rst = 1'b0;
    step();
    checks++;
    if (bv0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle: valid=%b busy=%b, want 0 0", bv0, busy0);
    end
    load_block(8'h40);
    valid = 1'b1;
    step();
    valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (bv0 !== 1'b1 || byte0 !== 8'(64 + k)) begin
        errors++;
        $display("FAIL mid_d_byte%0d: valid=%b byte=%h, want 1 %h", k, bv0, byte0, 8'(64 + k));
      end
      step();
    end
    checks++;
    if (bv0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_d_end: valid=%b busy=%b done=%b, want 0 0 1", bv0, busy0, done0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ready_toggle();
    test_back_to_back();
    test_pending_full();
    test_gap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
